// File: rtl/n_to_one_stream_mux_if.sv
// Handshake bundle for n_to_one_stream_mux: NUM_CH producer channels in, one consumer out.
// The slave modport is the mux side; the master modport is the producer/consumer side.
interface n_to_one_stream_mux_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = 2
) ();
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [SEL_W-1:0]        sel;
    logic                    rr_mode;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;

    modport slave (
        input  in_data, in_valid, sel, rr_mode, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

    modport master (
        output in_data, in_valid, sel, rr_mode, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/n_to_one_stream_mux.sv
// N:1 valid/ready stream mux with a one-entry output register.
// Channel chosen by sel (direct mode) or by round-robin starting after the last RR grant.
// Optional transfer counter enabled by defining N_TO_ONE_STREAM_MUX_XFER_CNT_EN.
module n_to_one_stream_mux #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef N_TO_ONE_STREAM_MUX_XFER_CNT_EN
    input  logic                 clr_count,
    output logic [15:0]          xfer_count,
`endif
    n_to_one_stream_mux_if.slave bus
);
    localparam logic [SEL_W:0]   NumChExt = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] LastCh   = SEL_W'(NUM_CH - 1);

    logic [WIDTH-1:0]  out_data_q;
    logic [SEL_W-1:0]  out_ch_q;
    logic              out_valid_q;
    logic [SEL_W-1:0]  last_grant_q;

    logic              can_load;
    logic              grant_ok;
    logic [SEL_W-1:0]  grant;
    logic [SEL_W-1:0]  cand;
    logic [WIDTH-1:0]  grant_data;
    logic [NUM_CH-1:0] ready;
    logic              xfer;

    assign can_load = !out_valid_q || bus.out_ready;

    // Grant decode: direct select, or first valid channel after last_grant with wrap.
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        cand     = '0;
        if (!bus.rr_mode) begin
            grant    = bus.sel;
            grant_ok = ({1'b0, bus.sel} < NumChExt);
        end else begin
            for (int unsigned k = 1; k <= NUM_CH; k++) begin
                cand = SEL_W'((32'(last_grant_q) + k) % NUM_CH);
                if (!grant_ok && bus.in_valid[cand]) begin
                    grant_ok = 1'b1;
                    grant    = cand;
                end
            end
        end
    end

    // One-hot ready and data select for the granted channel; ready held low in reset.
    always_comb begin
        ready      = '0;
        grant_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (SEL_W'(i) == grant) begin
                grant_data = bus.in_data[i*WIDTH +: WIDTH];
                ready[i]   = rst_n && can_load && grant_ok;
            end
        end
    end

    assign xfer         = |(ready & bus.in_valid);
    assign bus.in_ready = ready;

    // Output register and RR state; direct-mode transfers leave last_grant alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_valid_q  <= 1'b0;
            last_grant_q <= LastCh;
        end else begin
            if (xfer) begin
                out_data_q  <= grant_data;
                out_ch_q    <= grant;
                out_valid_q <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (xfer && bus.rr_mode) begin
                last_grant_q <= grant;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

`ifdef N_TO_ONE_STREAM_MUX_XFER_CNT_EN
    logic [15:0] cnt_q;

    // Saturating transfer counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_count) begin
            cnt_q <= '0;
        end else if (xfer && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign xfer_count = cnt_q;
`endif

endmodule

// File: tb/tb_n_to_one_stream_mux.sv
// Directed bench for n_to_one_stream_mux: 4-channel DUT checked every cycle against a
// scoreboard model, plus a 3-channel DUT for the out-of-range select case.
module tb_n_to_one_stream_mux;
    logic clk;
    logic rst_n;

    n_to_one_stream_mux_if #(.WIDTH(8), .NUM_CH(4), .SEL_W(2)) bus4 ();
    n_to_one_stream_mux_if #(.WIDTH(8), .NUM_CH(3), .SEL_W(2)) bus3 ();

`ifdef N_TO_ONE_STREAM_MUX_XFER_CNT_EN
    logic        clr_count;
    logic [15:0] xfer_count4;
    logic [15:0] xfer_count3;
`endif

    n_to_one_stream_mux #(.WIDTH(8), .NUM_CH(4), .SEL_W(2)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef N_TO_ONE_STREAM_MUX_XFER_CNT_EN
        .clr_count  (clr_count),
        .xfer_count (xfer_count4),
`endif
        .bus        (bus4)
    );

    n_to_one_stream_mux #(.WIDTH(8), .NUM_CH(3), .SEL_W(2)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef N_TO_ONE_STREAM_MUX_XFER_CNT_EN
        .clr_count  (1'b0),
        .xfer_count (xfer_count3),
`endif
        .bus        (bus3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ch;
    } word_t;

    word_t       q[$];
    word_t       last_w;
    logic [1:0]  mlast;
    logic [15:0] m_cnt;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        last_w = '0;
        mlast  = 2'd3;
        m_cnt  = '0;
    endtask

    // Called just after an edge with inputs already applied; checks, predicts, advances.
    task automatic cycle();
        logic       canl;
        logic       gok;
        logic [1:0] g;
        logic [1:0] c;
        logic [3:0] er;
        logic       xf;
        #1;
        check("out_valid", bus4.out_valid, (q.size() != 0));
        if (q.size() != 0) begin
            check("out_data", bus4.out_data, q[0].data);
            check("out_ch", bus4.out_ch, q[0].ch);
        end else begin
            check("hold_data", bus4.out_data, last_w.data);
            check("hold_ch", bus4.out_ch, last_w.ch);
        end
        canl = (q.size() == 0) || bus4.out_ready;
        if (q.size() != 0 && bus4.out_ready) last_w = q.pop_front();
        gok = 1'b0;
        g   = 2'd0;
        if (!bus4.rr_mode) begin
            gok = 1'b1;
            g   = bus4.sel;
        end else begin
            for (int k = 1; k <= 4; k++) begin
                c = mlast + 2'(k);
                if (!gok && bus4.in_valid[c]) begin
                    gok = 1'b1;
                    g   = c;
                end
            end
        end
        er = (canl && gok) ? (4'b0001 << g) : 4'b0000;
        check("in_ready", bus4.in_ready, er);
        xf = canl && gok && bus4.in_valid[g];
        if (xf) begin
            q.push_back('{data: bus4.in_data[g*8 +: 8], ch: g});
            if (bus4.rr_mode) mlast = g;
        end
`ifdef N_TO_ONE_STREAM_MUX_XFER_CNT_EN
        check("xfer_count", xfer_count4, m_cnt);
        if (clr_count) m_cnt = '0;
        else if (xf && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model_reset();
        rst_n = 1'b0;
`ifdef N_TO_ONE_STREAM_MUX_XFER_CNT_EN
        clr_count = 1'b0;
`endif
        // Inputs request a transfer during reset: ready must stay low.
        bus4.in_data   = 32'hD3A5B1C0;
        bus4.in_valid  = 4'b1111;
        bus4.sel       = 2'd1;
        bus4.rr_mode   = 1'b0;
        bus4.out_ready = 1'b1;
        bus3.in_data   = 24'h3C5A77;
        bus3.in_valid  = 3'b111;
        bus3.sel       = 2'd0;
        bus3.rr_mode   = 1'b0;
        bus3.out_ready = 1'b1;
        #2;
        check("rst_ready4", bus4.in_ready, 4'b0000);
        check("rst_ready3", bus3.in_ready, 3'b000);
        check("rst_valid", bus4.out_valid, 1'b0);
        check("rst_data", bus4.out_data, 8'h00);
        check("rst_ch", bus4.out_ch, 2'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Direct mode, sel=2.
        bus4.sel = 2'd2;
        cycle();
        check("dir_data", bus4.out_data, 8'hA5);
        check("dir_ch", bus4.out_ch, 2'd2);
        bus4.in_valid = 4'b0000;
        cycle();
        cycle();

        // 3-channel build: sel=2 loads, sel=3 has no grant and output drains.
        bus3.sel = 2'd2;
        #1;
        check("n3_ready_sel2", bus3.in_ready, 3'b100);
        @(posedge clk);
        #1;
        check("n3_valid", bus3.out_valid, 1'b1);
        check("n3_data", bus3.out_data, 8'h3C);
        check("n3_ch", bus3.out_ch, 2'd2);
        bus3.sel = 2'd3;
        #1;
        check("n3_ready_sel3", bus3.in_ready, 3'b000);
        @(posedge clk);
        #1;
        check("n3_drained", bus3.out_valid, 1'b0);
        check("n3_hold", bus3.out_data, 8'h3C);
        bus3.in_valid = 3'b000;

        // Round robin, all valid: 0,1,2,3,0,1,2,3.
        bus4.rr_mode  = 1'b1;
        bus4.in_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            bus4.in_data = $urandom;
            cycle();
            check("rr_all", bus4.out_ch, 32'(k % 4));
        end
        // Only ch1 and ch3 valid: 1,3,1,3.
        bus4.in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            bus4.in_data = $urandom;
            cycle();
            check("rr_pair", bus4.out_ch, (k % 2 == 1) ? 32'd3 : 32'd1);
        end

        // Mode switch: last_grant=1, two direct sel=0 transfers, RR resumes at 2.
        bus4.in_valid = 4'b0010;
        cycle();
        bus4.rr_mode  = 1'b0;
        bus4.sel      = 2'd0;
        bus4.in_valid = 4'b1111;
        cycle();
        cycle();
        check("dir_ch0", bus4.out_ch, 2'd0);
        bus4.rr_mode = 1'b1;
        cycle();
        check("mode_sw", bus4.out_ch, 2'd2);

        // Backpressure then release with no bubble.
        bus4.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus4.in_data = $urandom;
            cycle();
        end
        check("bp_ready", bus4.in_ready, 4'b0000);
        check("bp_ch", bus4.out_ch, 2'd2);
        bus4.out_ready = 1'b1;
        cycle();
        check("bp_refill_ch", bus4.out_ch, 2'd3);
        check("bp_refill_v", bus4.out_valid, 1'b1);

        // Asynchronous reset while a word is held.
        bus4.out_ready = 1'b0;
        cycle();
        rst_n = 1'b0;
        #1;
        check("arst_valid", bus4.out_valid, 1'b0);
        check("arst_data", bus4.out_data, 8'h00);
        check("arst_ch", bus4.out_ch, 2'd0);
        check("arst_ready", bus4.in_ready, 4'b0000);
        model_reset();
        @(posedge clk);
        #1;
        check("arst_ready2", bus4.in_ready, 4'b0000);
        rst_n          = 1'b1;
        bus4.out_ready = 1'b1;
        cycle();
        check("post_rst_ch", bus4.out_ch, 2'd0);

`ifdef N_TO_ONE_STREAM_MUX_XFER_CNT_EN
        // Counter: clear, 10 transfers, then run to saturation, then clear vs increment.
        bus4.rr_mode  = 1'b0;
        bus4.sel      = 2'd1;
        bus4.in_valid = 4'b1111;
        clr_count     = 1'b1;
        cycle();
        clr_count = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        check("cnt_10", xfer_count4, 16'd10);
        for (int k = 0; k < 65524; k++) cycle();
        check("cnt_fffe", xfer_count4, 16'hFFFE);
        for (int k = 0; k < 3; k++) cycle();
        check("cnt_sat", xfer_count4, 16'hFFFF);
        clr_count = 1'b1;
        cycle();
        clr_count = 1'b0;
        check("cnt_clr", xfer_count4, 16'h0000);
`endif

        bus4.in_valid = 4'b0000;
        cycle();
        cycle();
        check("final_idle", bus4.out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/n_to_one_stream_mux.md
Name: n_to_one_stream_mux

Overview:
- Parametrised successor to the team's 2:1 combinational mux.
- Selects one of NUM_CH WIDTH-bit input channels onto a single output through valid/ready handshakes.
- Selection is either by a select line (direct mode) or by fair round-robin arbitration (RR mode).
- Result is held in a one-entry output register. Sits between multiple producers and one consumer in the datapath.

Parameters:
- WIDTH, 8, data bits per channel.
- NUM_CH, 4, number of input channels; legal range 2..16.
- SEL_W, 2, select/channel-index width; must equal ceil(log2(NUM_CH)).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_CH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; combinational.
- sel  input  SEL_W  channel select, used in direct mode.
- rr_mode  input  1  0 = direct select, 1 = round-robin.
- out_data  output  WIDTH  registered output data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a valid word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset: asynchronous on rst_n low. out_valid=0, out_data=0, out_ch=0, last_grant=NUM_CH-1 (so channel 0 wins first in RR mode). All in_ready are 0 while rst_n is low.
- can_load = !out_valid || out_ready. The register is empty, or is draining this cycle.
- Grant in direct mode:
  - grant = sel if sel < NUM_CH.
  - If sel >= NUM_CH, there is no grant and all in_ready are 0.
  - in_valid on unselected channels is ignored.
- Grant in RR mode:
  - Search channels last_grant+1, last_grant+2, ... with wrap modulo NUM_CH.
  - The first channel with in_valid=1 wins. If none is valid, there is no grant.
- in_ready[i] = can_load && (i == grant). At most one in_ready bit is high; decoded combinationally from the current inputs.
- Transfer occurs when in_valid[grant] && in_ready[grant]. On the next edge: out_data = that channel's data, out_ch = grant, out_valid = 1, last_grant = grant.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle when out_ready is held high.
- Drain without refill (out_valid && out_ready, no transfer): out_valid -> 0. out_data and out_ch hold their last values.
- Backpressure: while out_valid && !out_ready, out_data and out_ch are stable and all in_ready are 0.
- last_grant changes only on a transfer, and only in RR mode. Direct-mode transfers do not disturb RR fairness state.
- rr_mode or sel changing mid-stream: takes effect in the same cycle's grant decode. A word already in the output register is unaffected.
- Reset mid-operation: any held word is discarded immediately and state returns to reset values.

Optional Feature:
- Macro: N_TO_ONE_STREAM_MUX_XFER_CNT_EN.
- When defined:
  - Adds output port xfer_count, 16 bits.
  - Increments by 1 on every input transfer and saturates at 0xFFFF (no wrap).
  - Reset value 0.
  - Adds input clr_count, 1 bit: synchronous clear to 0. clr_count has priority over a simultaneous increment.
- When undefined: neither port exists, no counter logic; all other behaviour is identical.

Test Plan:
- Reset: rst_n low mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 asynchronously; in_ready=0 until rst_n high.
- Direct mode, WIDTH=8, NUM_CH=4: rr_mode=0, sel=2, in_valid=4'b1111, ch2 data=8'hA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=8'hA5, out_ch=2, out_valid=1. Then sel=3'd? not applicable; with NUM_CH=3 build and sel=3 -> in_ready=0, out_valid falls to 0.
- RR fairness: rr_mode=1, all in_valid=1, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3. Then only ch1 and ch3 valid -> alternates 1,3,1,3.
- Backpressure: out_valid=1, out_ready=0 for 5 cycles with in_valid=4'b1111 -> out_data/out_ch constant, in_ready=0. Raise out_ready -> new word loaded the same cycle the old one drains (no bubble).
- Mode switch: RR mode with last_grant=1, switch to direct sel=0 for 2 transfers, back to RR with all valid -> next grant is 2 (last_grant untouched by direct mode).
- With N_TO_ONE_STREAM_MUX_XFER_CNT_EN defined: 10 transfers -> xfer_count=10. Preload to 0xFFFE, 3 transfers -> 0xFFFF. clr_count=1 with a simultaneous transfer -> 0.
